// File: rtl/car_gate_pkg.sv
// Shared encodings for the car gate: sequencer states, travel direction and
// the {a,b} light-barrier sensor codes.
package car_gate_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned SENS_W  = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_P1   = 3'd1,
        ST_P2   = 3'd2,
        ST_P3   = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    localparam logic DIR_IN  = 1'b0;
    localparam logic DIR_OUT = 1'b1;

    // Bit 1 is sensor a, bit 0 is sensor b.
    localparam logic [SENS_W-1:0] SENS_CLEAR = 2'b00;
    localparam logic [SENS_W-1:0] SENS_A     = 2'b10;
    localparam logic [SENS_W-1:0] SENS_B     = 2'b01;
    localparam logic [SENS_W-1:0] SENS_BOTH  = 2'b11;

    // Sensor pattern shown while in a given state for a given direction.
    function automatic logic [SENS_W-1:0] phase_code(input state_t st, input logic dir);
        logic [SENS_W-1:0] code;
        code = SENS_CLEAR;
        case (st)
            ST_P1:   code = (dir == DIR_IN) ? SENS_A : SENS_B;
            ST_P2:   code = SENS_BOTH;
            ST_P3:   code = (dir == DIR_IN) ? SENS_B : SENS_A;
            default: code = SENS_CLEAR;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that holds at zero; zero_c flags the final cycle of a phase.
module phase_timer #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic [DW-1:0] load_val,
    output logic          zero_c
);

    logic [DW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - DW'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/car_sequence_gen.sv
// Plays back the two-sensor waveform of one car passing the gate (entry or exit)
// with a programmable per-phase dwell, then a fixed idle gap; counts completions.
module car_sequence_gen
    import car_gate_pkg::*;
#(
    parameter int unsigned DW         = 8,
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    input  logic             cmd_dir,
    input  logic [DW-1:0]    cmd_dwell,
    output logic             cmd_ready,
    input  logic             abort,
    output logic             sensor_a,
    output logic             sensor_b,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] n_in,
    output logic [CNT_W-1:0] n_out
);

    localparam logic [DW-1:0] GAP_LOAD = DW'(GAP_CYCLES - 1);

    state_t            state_q, state_d;
    logic              dir_q, dir_d;
    logic [DW-1:0]     dwell_q, dwell_d;
    logic [SENS_W-1:0] sens_q, sens_d;
    logic              done_d, aborted_d;
    logic              inc_in, inc_out;
    logic              ready_q, busy_q;
    logic [CNT_W-1:0]  n_in_q, n_out_q;
    logic              tmr_load;
    logic [DW-1:0]     tmr_val;
    logic              tmr_zero_c;
    logic [DW-1:0]     eff_dwell_c;

    // A zero dwell would give an empty phase; stretch it to one cycle.
    assign eff_dwell_c = (cmd_dwell == '0) ? DW'(1) : cmd_dwell;

    phase_timer #(
        .DW(DW)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero_c   (tmr_zero_c)
    );

    // State, latched command and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_IN;
            dwell_q <= DW'(1);
            sens_q  <= SENS_CLEAR;
            done    <= 1'b0;
            aborted <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            dwell_q <= dwell_d;
            sens_q  <= sens_d;
            done    <= done_d;
            aborted <= aborted_d;
            ready_q <= (state_d == ST_IDLE);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    // Next-state, timer control and output decode.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        dwell_d   = dwell_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        inc_in    = 1'b0;
        inc_out   = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = dwell_q - DW'(1);

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d  = ST_P1;
                    dir_d    = cmd_dir;
                    dwell_d  = eff_dwell_c;
                    tmr_load = 1'b1;
                    tmr_val  = eff_dwell_c - DW'(1);
                end
            end
            ST_P1: begin
                if (tmr_zero_c) begin
                    state_d  = ST_P2;
                    tmr_load = 1'b1;
                end
            end
            ST_P2: begin
                if (tmr_zero_c) begin
                    state_d  = ST_P3;
                    tmr_load = 1'b1;
                end
            end
            ST_P3: begin
                if (tmr_zero_c) begin
                    state_d  = ST_GAP;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (tmr_zero_c) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    inc_in  = (dir_q == DIR_IN);
                    inc_out = (dir_q == DIR_OUT);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides any progress, but only while a sequence is running.
        if (abort && (state_q inside {ST_P1, ST_P2, ST_P3, ST_GAP})) begin
            state_d   = ST_IDLE;
            aborted_d = 1'b1;
            done_d    = 1'b0;
            inc_in    = 1'b0;
            inc_out   = 1'b0;
            tmr_load  = 1'b0;
        end
    end

    assign sens_d = phase_code(state_d, dir_d);

    // Completion counters wrap silently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n_in_q  <= '0;
            n_out_q <= '0;
        end else begin
            if (inc_in) begin
                n_in_q <= n_in_q + CNT_W'(1);
            end
            if (inc_out) begin
                n_out_q <= n_out_q + CNT_W'(1);
            end
        end
    end

    assign sensor_a  = sens_q[1];
    assign sensor_b  = sens_q[0];
    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign n_in      = n_in_q;
    assign n_out     = n_out_q;

endmodule

// File: tb/tb_car_sequence_gen.sv
// Randomized and directed bench for car_sequence_gen against a queue-based
// waveform model and a pattern-matching car detector.
module tb_car_sequence_gen;

    localparam int unsigned DW    = 8;
    localparam int unsigned GAP   = 4;
    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             reset_n;
    logic             cmd_valid;
    logic             cmd_dir;
    logic [DW-1:0]    cmd_dwell;
    logic             cmd_ready;
    logic             abort;
    logic             sensor_a;
    logic             sensor_b;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [CNT_W-1:0] n_in;
    logic [CNT_W-1:0] n_out;

    car_sequence_gen #(
        .DW(DW), .GAP_CYCLES(GAP), .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_dir   (cmd_dir),
        .cmd_dwell (cmd_dwell),
        .cmd_ready (cmd_ready),
        .abort     (abort),
        .sensor_a  (sensor_a),
        .sensor_b  (sensor_b),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .n_in      (n_in),
        .n_out     (n_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: the whole busy waveform is queued up front at acceptance.
    logic [1:0] entry_code [3] = '{2'b10, 2'b11, 2'b01};
    logic [1:0] exit_code  [3] = '{2'b01, 2'b11, 2'b10};
    logic [1:0] plan [$];
    logic       e_busy, e_done, e_abrt, m_dir;
    logic [1:0] e_sens;
    logic [CNT_W-1:0] e_nin, e_nout;

    task automatic model_reset();
        plan.delete();
        e_busy = 0; e_done = 0; e_abrt = 0; m_dir = 0;
        e_sens = 2'b00; e_nin = '0; e_nout = '0;
    endtask

    task automatic model_step(input logic v, input logic d, input logic [DW-1:0] dw, input logic ab);
        int dd;
        e_done = 0;
        e_abrt = 0;
        if (e_busy) begin
            if (ab) begin
                plan.delete();
                e_busy = 0; e_sens = 2'b00; e_abrt = 1;
            end else if (plan.size() > 0) begin
                e_sens = plan.pop_front();
            end else begin
                e_busy = 0; e_sens = 2'b00; e_done = 1;
                if (m_dir) e_nout++;
                else       e_nin++;
            end
        end else if (v) begin
            m_dir = d;
            dd = (dw == 0) ? 1 : int'(dw);
            for (int p = 0; p < 3; p++)
                for (int k = 0; k < dd; k++)
                    plan.push_back(d ? exit_code[p] : entry_code[p]);
            for (int k = 0; k < int'(GAP); k++) plan.push_back(2'b00);
            e_sens = plan.pop_front();
            e_busy = 1;
        end
    endtask

    // Independent car detector: a complete a/ab/b (or b/ab/a) run closed by 00.
    logic [1:0] seen [$];
    int det_in, det_out;

    task automatic detect();
        logic [1:0] s;
        s = {sensor_a, sensor_b};
        if (s == 2'b00) begin
            if (seen.size() == 3 && seen[0] == 2'b10 && seen[1] == 2'b11 && seen[2] == 2'b01) det_in++;
            else if (seen.size() == 3 && seen[0] == 2'b01 && seen[1] == 2'b11 && seen[2] == 2'b10) det_out++;
            seen.delete();
        end else if (seen.size() == 0 || seen[$] != s) begin
            seen.push_back(s);
        end
    endtask

    task automatic check_cycle(input string tag);
        check_val(tag, 32'({sensor_a, sensor_b, busy, cmd_ready, done, aborted, n_in, n_out}),
                       32'({e_sens, e_busy, !e_busy, e_done, e_abrt, e_nin, e_nout}));
    endtask

    task automatic step(input logic v, input logic d, input logic [DW-1:0] dw, input logic ab);
        cmd_valid = v; cmd_dir = d; cmd_dwell = dw; abort = ab;
        @(posedge clk);
        model_step(v, d, dw, ab);
        @(negedge clk);
        check_cycle("cycle");
        detect();
    endtask

    task automatic drain();
        for (int k = 0; k < 2000 && e_busy; k++) step(0, 0, '0, 0);
        step(0, 0, '0, 0);
    endtask

    logic             dirs [8];
    logic             tmp;
    logic [CNT_W-1:0] n0;
    int               j;

    initial begin
        reset_n = 0; cmd_valid = 0; cmd_dir = 0; cmd_dwell = '0; abort = 0;
        model_reset();
        det_in = 0; det_out = 0;
        repeat (2) @(negedge clk);
        reset_n = 1;
        check_cycle("reset");

        // Entry, dwell 3: done at T14.
        step(1, 0, 8'd3, 0);
        check_val("entry_t1_sens", 32'({sensor_a, sensor_b}), 32'(2'b10));
        repeat (13) step(0, 0, '0, 0);
        check_val("entry_t14_done", 32'(done), 32'd1);
        check_val("entry_t14_nin", 32'(n_in), 32'd1);
        check_val("entry_t14_nout", 32'(n_out), 32'd0);

        // Exit, dwell 0 behaves as 1: done at T8.
        step(1, 1, 8'd0, 0);
        check_val("exit_t1_sens", 32'({sensor_a, sensor_b}), 32'(2'b01));
        repeat (7) step(0, 0, '0, 0);
        check_val("exit_t8_done", 32'(done), 32'd1);
        check_val("exit_t8_nout", 32'(n_out), 32'd1);

        // Abort in the second P2 cycle of an entry with dwell 3.
        step(1, 0, 8'd3, 0);
        repeat (4) step(0, 0, '0, 0);
        check_val("abort_pre_sens", 32'({sensor_a, sensor_b}), 32'(2'b11));
        step(0, 0, '0, 1);
        check_val("abort_sens", 32'({sensor_a, sensor_b}), 32'(2'b00));
        check_val("abort_pulse", 32'(aborted), 32'd1);
        check_val("abort_nodone", 32'(done), 32'd0);
        check_val("abort_nin", 32'(n_in), 32'd1);
        check_val("abort_ready", 32'(cmd_ready), 32'd1);
        step(0, 0, '0, 1);
        check_val("abort_idle_ignored", 32'(aborted), 32'd0);

        // Back-to-back exit, stray valid mid-sequence, valid held into done cycle.
        step(1, 1, 8'd2, 0);
        for (int i = 2; i <= 11; i++)
            step((i == 4) || (i >= 10), (i == 4) ? 1'b0 : 1'b1, 8'd2, 0);
        check_val("b2b_done", 32'(done), 32'd1);
        step(1, 1, 8'd2, 1);
        check_val("b2b_p1_sens", 32'({sensor_a, sensor_b}), 32'(2'b01));
        check_val("b2b_busy", 32'(busy), 32'd1);
        drain();
        check_val("b2b_nout", 32'(n_out), 32'd3);

        // Asynchronous reset in the middle of P3.
        step(1, 0, 8'd3, 0);
        repeat (7) step(0, 0, '0, 0);
        check_val("p3_sens", 32'({sensor_a, sensor_b}), 32'(2'b01));
        #2 reset_n = 0;
        #1;
        check_val("arst_sens", 32'({sensor_a, sensor_b}), 32'(2'b00));
        check_val("arst_cnt", 32'({n_in, n_out}), 32'd0);
        check_val("arst_ready", 32'({cmd_ready, busy}), 32'(2'b10));
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1;
        check_cycle("arst_release");

        // Closed loop: 5 entries and 3 exits in shuffled order.
        for (int i = 0; i < 8; i++) dirs[i] = (i >= 5);
        for (int i = 7; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            tmp = dirs[i]; dirs[i] = dirs[j]; dirs[j] = tmp;
        end
        seen.delete(); det_in = 0; det_out = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, dirs[i], DW'($urandom_range(0, 3)), 0);
            drain();
        end
        check_val("loop_det_in", 32'(det_in), 32'd5);
        check_val("loop_det_out", 32'(det_out), 32'd3);
        check_val("loop_nin", 32'(n_in), 32'd5);
        check_val("loop_nout", 32'(n_out), 32'd3);

        // Counter wrap: 256 back-to-back entries of dwell 1 return n_in to its start.
        n0 = e_nin;
        repeat (256 * 8) step(1, 0, 8'd1, 0);
        check_val("wrap_done", 32'(done), 32'd1);
        check_val("wrap_nin", 32'(n_in), 32'(n0));
        step(0, 0, '0, 0);

        // Randomized traffic with occasional aborts and long dwells.
        repeat (3000) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0) ? DW'($urandom_range(6, 40)) : DW'($urandom_range(0, 5)),
                 1'($urandom_range(0, 29) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/car_sequence_gen.md
Name: car_sequence_gen

Overview:
- Generates the two-sensor light-barrier waveforms (sensor_a, sensor_b) that a single car produces when it drives through the gate, in the entry or the exit direction.
- Feeds the car-detection FSM on the demo board and in benches, so car counting can be exercised without physical sensors.
- Accepts one command at a time through a valid/ready handshake.
- Plays back the phase sequence with a programmable dwell time per phase, then a guaranteed idle gap.
- Signals completion or abort, and keeps entry/exit completion counters.

Parameters:
DW, 8, width of the dwell input and the phase timer
GAP_CYCLES, 4, cycles with both sensors clear after the last phase (legal range 1..2^DW-1)
CNT_W, 8, width of the completed-sequence counters

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_dir  input  1  0 = entry (a first), 1 = exit (b first)
cmd_dwell  input  DW  cycles per phase; 0 is treated as 1
cmd_ready  output  1  high only in IDLE
abort  input  1  cancel the running sequence
sensor_a  output  1  sensor 'a' blocked
sensor_b  output  1  sensor 'b' blocked
busy  output  1  sequence in progress (state != IDLE)
done  output  1  one-cycle pulse: sequence completed
aborted  output  1  one-cycle pulse: sequence cancelled
n_in  output  CNT_W  completed entries, wraps modulo 2^CNT_W
n_out  output  CNT_W  completed exits, wraps modulo 2^CNT_W

Behaviour:
- Reset (async assert, sync release): state IDLE; sensor_a, sensor_b, done, aborted = 0; n_in, n_out = 0; cmd_ready = 1.
- cmd_ready is decoded from the registered state: 1 exactly in IDLE.
- Accept: cmd_valid && cmd_ready at edge T0 latches cmd_dir and max(cmd_dwell,1); cmd_valid is ignored while not ready.
- States: IDLE -> P1 -> P2 -> P3 -> GAP -> IDLE.
- Sensor outputs are registered and change at the same edge as the state.
- Entry codes {a,b}: P1 = 10, P2 = 11, P3 = 01. Exit codes: P1 = 01, P2 = 11, P3 = 10. GAP and IDLE = 00.
- Phase timing: P1 spans T1..Td. Each P state lasts exactly d cycles, where d is the latched dwell. GAP lasts exactly GAP_CYCLES cycles.
- Completion: on the first IDLE cycle after GAP, done = 1 for one cycle and cmd_ready = 1. n_in (dir 0) or n_out (dir 1) is incremented at that same edge.
- Back-to-back: a command accepted in the cycle done is high starts P1 on the next edge. Minimum spacing between sequences is therefore 3d + GAP_CYCLES + 1 cycles.
- Abort:
  - abort = 1 in P1, P2, P3 or GAP: next edge goes to IDLE with sensors 00, aborted = 1 for one cycle, no done, counters unchanged.
  - abort in IDLE is ignored, including when it coincides with an accepted command (the command wins).
- Phase timer: down-counter loaded with d-1 on entry to each P state and GAP_CYCLES-1 on entry to GAP. The state advances when the counter is 0.
- Inputs are sampled only at acceptance; changes to cmd_dir or cmd_dwell during a sequence have no effect.
- Illegal state codes return to IDLE with sensors 00 and no pulses.
- Counter wrap: 2^CNT_W-1 + 1 -> 0, with no flag.

Decomposition:
- Shared package car_gate_pkg holds:
  - the state encoding (IDLE, P1, P2, P3, GAP);
  - the direction constants DIR_IN = 0, DIR_OUT = 1;
  - the sensor code constants SENS_CLEAR = 00, SENS_A = 10, SENS_B = 01, SENS_BOTH = 11.
- The car-detection FSM reuses the same package for its sensor codes.
- One sub-module, phase_timer: loadable DW-bit down-counter with load, load value and a zero flag.
- The completion counters stay inline.

Test Plan:
- Entry, dwell = 3, GAP_CYCLES = 4, accepted at T0 -> {a,b} = 10 for T1..T3, 11 for T4..T6, 01 for T7..T9, 00 for T10..T13. At T14: done = 1, cmd_ready = 1, n_in = 1, n_out = 0.
- Exit, dwell = 0 -> treated as 1: 01 at T1, 11 at T2, 10 at T3, 00 for T4..T7. done at T8, n_out = 1.
- Abort asserted during the second P2 cycle of an entry with dwell = 3 -> next cycle sensors 00, aborted = 1, done = 0, n_in unchanged, cmd_ready = 1.
- Back-to-back: new exit command held valid during the done cycle -> accepted there, 01 on the following cycle. cmd_valid pulsed mid-sequence is ignored (no second sequence).
- reset_n asserted low asynchronously mid-P3 -> sensors 00 and counters 0 immediately, without waiting for a clock edge. After release: IDLE, ready = 1.
- Closed loop with the car-detection FSM: 5 entries and 3 exits -> exactly 5 carIn pulses and 3 carOut pulses, matching n_in = 5, n_out = 3.
